spi_slave: RTL and testbench

//  SPI bus slave: responder counterpart to the SPI master, for peripherals on the same bus.

---
 rtl/spi_slave.sv | 181 ++++++++++++++++++
 tb/tb_spi_slave.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// spi_slave
//   SPI bus slave for peripherals sharing a bus with the SPI master. The
//   asynchronous sck, ss_n and mosi pins are oversampled in the clk domain.
//   Transfers are full duplex, MSB first, in any of the four CPOL/CPHA modes.
//   The host side sees a one-deep transmit buffer and a received-byte strobe.
//
// Ports
//   clk, reset   system clock, synchronous active-high reset
//   sck, ss_n    SPI clock and active-low slave select (asynchronous)
//   mosi, miso   serial data in / out (miso is 0 while deselected)
//   cpol, cpha   bus mode, captured when a transfer starts
//   tx_data      next byte to send, written by tx_load when tx_ready=1
//   tx_ready     transmit buffer is empty
//   rx_data      last complete received byte, rx_valid pulses on update
//   underrun     pulses when a byte starts with the transmit buffer empty
//   selected     slave select is active and a transfer is in progress
module spi_slave #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sck,
   input  logic             ss_n,
   input  logic             mosi,
   output logic             miso,
   input  logic             cpol,
   input  logic             cpha,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_load,
   output logic             tx_ready,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   output logic             underrun,
   output logic             selected
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sck_sync;
   logic [SYNC_STAGES-1:0] ss_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   sck_d;
   logic                   ss_d;
   logic                   sck_s;
   logic                   ss_s;
   logic                   mosi_s;
   logic                   sck_rise;
   logic                   sck_fall;
   logic                   ss_rise;
   logic                   ss_fall;
   logic                   sample_edge;
   logic                   shift_edge;
   logic                   cpol_q;
   logic                   cpha_q;
   logic [CW-1:0]          count;
   logic [WIDTH-1:0]       rx_sr;
   logic [WIDTH-1:0]       tx_sr;
   logic [WIDTH-1:0]       tx_buf;
   logic [WIDTH-1:0]       next_word;
   logic                   byte_done;
   logic                   start;
   logic                   reload;
   logic                   xfer;
   logic                   load_ok;

   // Synchronizer chains plus one delayed copy of sck and ss_n for edge
   // detection. Everything resets to 0 so that an ss_n held low through
   // reset never looks like a falling edge: the master must deselect first.
   always_ff @(posedge clk) begin
      if (reset) begin
         sck_sync  <= '0;
         ss_sync   <= '0;
         mosi_sync <= '0;
         sck_d     <= 1'b0;
         ss_d      <= 1'b0;
      end else begin
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         sck_d     <= sck_sync[SYNC_STAGES-1];
         ss_d      <= ss_sync[SYNC_STAGES-1];
      end
   end

   assign sck_s    = sck_sync[SYNC_STAGES-1];
   assign ss_s     = ss_sync[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_d;
   assign sck_fall = ~sck_s & sck_d;
   assign ss_rise  = ss_s & ~ss_d;
   assign ss_fall  = ~ss_s & ss_d;

   // Modes 0 and 3 sample on the rising sck edge, modes 1 and 2 on the
   // falling edge; the other edge moves miso.
   assign sample_edge = (cpol_q == cpha_q) ? sck_rise : sck_fall;
   assign shift_edge  = (cpol_q == cpha_q) ? sck_fall : sck_rise;

   // A byte boundary (transfer start or back-to-back reload) moves the
   // buffer into the shift register; an empty buffer sends all ones.
   assign byte_done = (count == CW'(WIDTH));
   assign start     = (state == IDLE) & ss_fall;
   assign reload    = (state == SHIFT) & ~ss_rise & byte_done;
   assign xfer      = start | reload;
   assign load_ok   = tx_load & tx_ready;
   assign next_word = tx_ready ? {WIDTH{1'b1}} : tx_buf;
   assign selected  = (state == SHIFT) & ~ss_s;

   // Main FSM with the transmit buffer and registered host outputs.
   // A shift edge while the bit count is zero leaves the MSB on miso: in
   // CPHA=1 that is the leading edge of a byte, in CPHA=0 it is the trailing
   // edge of the previous byte arriving after the reload.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cpol_q   <= 1'b0;
         cpha_q   <= 1'b0;
         count    <= '0;
         rx_sr    <= '0;
         tx_sr    <= '0;
         tx_buf   <= '0;
         tx_ready <= 1'b1;
         miso     <= 1'b0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         underrun <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         underrun <= 1'b0;

         if (load_ok) begin
            tx_buf   <= tx_data;
            tx_ready <= 1'b0;
         end else if (xfer) begin
            tx_ready <= 1'b1;
         end

         if (xfer) begin
            tx_sr    <= next_word;
            miso     <= next_word[WIDTH-1];
            underrun <= tx_ready;
            count    <= '0;
         end

         case (state)
            IDLE: begin
               if (ss_fall) begin
                  state  <= SHIFT;
                  cpol_q <= cpol;
                  cpha_q <= cpha;
               end
            end
            SHIFT: begin
               if (ss_rise) begin
                  state <= IDLE;
                  miso  <= 1'b0;
                  count <= '0;
                  if (byte_done) begin
                     rx_data  <= rx_sr;
                     rx_valid <= 1'b1;
                  end
               end else if (byte_done) begin
                  rx_data  <= rx_sr;
                  rx_valid <= 1'b1;
               end else if (sample_edge) begin
                  rx_sr <= {rx_sr[WIDTH-2:0], mosi_s};
                  count <= count + CW'(1);
               end else if (shift_edge && count != '0) begin
                  tx_sr <= {tx_sr[WIDTH-2:0], 1'b0};
                  miso  <= tx_sr[WIDTH-2];
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave
//   Self-checking bench for spi_slave. A bench-side SPI master runs each
//   transfer at clk/8 in the requested mode, capturing miso on the master's
//   sample edge. Directed table vectors carry hand-derived expectations;
//   random vectors are predicted by a byte-level model of the transmit
//   buffer and received data.
module tb_spi_slave;

   localparam int HALF = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       sck;
   logic       ss_n;
   logic       mosi;
   logic       miso;
   logic       cpol;
   logic       cpha;
   logic [7:0] tx_data;
   logic       tx_load;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       underrun;
   logic       selected;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic            cpol;
      logic            cpha;
      logic            pre_en;
      logic [7:0]      pre;
      logic            pre2_en;
      logic [7:0]      pre2;
      int              nbytes;
      int              nbits;
      logic [1:0][7:0] mo;
      logic [1:0]      ml;
      logic [1:0][7:0] mlv;
      logic [1:0][7:0] exp_mi;
      int              exp_rx_n;
      logic [1:0][7:0] exp_rx;
      int              exp_und;
   } vec_t;

   vec_t tbl[10];

   // Byte-level model state: buffer contents and last delivered byte.
   logic       mdl_full;
   logic [7:0] mdl_buf;
   logic [7:0] mdl_last_rx;

   // Received bytes and underrun pulses logged as they happen.
   logic [7:0] rx_log[$];
   int         und_total = 0;

   always #5 clk = ~clk;

   spi_slave #(.WIDTH(8), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset), .sck(sck), .ss_n(ss_n), .mosi(mosi),
      .miso(miso), .cpol(cpol), .cpha(cpha), .tx_data(tx_data),
      .tx_load(tx_load), .tx_ready(tx_ready), .rx_data(rx_data),
      .rx_valid(rx_valid), .underrun(underrun), .selected(selected)
   );

   // Record every rx_valid pulse and count underrun pulses.
   always @(negedge clk) begin
      if (!reset) begin
         if (rx_valid) rx_log.push_back(rx_data);
         if (underrun) und_total = und_total + 1;
      end
   end

   // Hard stop in case the run ever stalls.
   initial begin
      #5ms;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic halfWait();
      tick(1);
      tx_load = 1'b0;
      tick(HALF - 1);
   endtask

   function automatic vec_t mk(input logic cpl, input logic cph, input logic pe,
                               input logic [7:0] pv, input int nby, input int nbi,
                               input logic [7:0] m0, input logic [7:0] m1,
                               input logic l0, input logic [7:0] lv0,
                               input logic [7:0] e0, input logic [7:0] e1,
                               input int ern, input logic [7:0] r0,
                               input logic [7:0] r1, input int eu);
      vec_t v;
      v.cpol = cpl;  v.cpha = cph;
      v.pre_en = pe; v.pre = pv; v.pre2_en = 1'b0; v.pre2 = 8'h00;
      v.nbytes = nby; v.nbits = nbi;
      v.mo[0] = m0; v.mo[1] = m1;
      v.ml = {1'b0, l0}; v.mlv[0] = lv0; v.mlv[1] = 8'h00;
      v.exp_mi[0] = e0; v.exp_mi[1] = e1;
      v.exp_rx_n = ern; v.exp_rx[0] = r0; v.exp_rx[1] = r1;
      v.exp_und = eu;
      return v;
   endfunction

   // Byte-level prediction: a load lands only in an empty buffer, every
   // byte start takes the buffer (or 0xFF plus an underrun), and every
   // completed byte is delivered and triggers the next buffer take.
   task automatic modelPredict(input vec_t vi, output vec_t vo);
      logic [7:0] cur;
      vo = vi;
      vo.exp_mi = '0; vo.exp_rx = '0; vo.exp_rx_n = 0; vo.exp_und = 0;
      if (vi.pre_en && !mdl_full) begin mdl_buf = vi.pre; mdl_full = 1'b1; end
      if (vi.pre2_en && !mdl_full) begin mdl_buf = vi.pre2; mdl_full = 1'b1; end
      cur = mdl_full ? mdl_buf : 8'hFF;
      if (!mdl_full) vo.exp_und += 1;
      mdl_full = 1'b0;
      for (int k = 0; k < vi.nbytes; k++) begin
         if (vi.nbits > 8 * k) begin
            vo.exp_mi[k] = cur;
            if (vi.ml[k] && vi.nbits > 8 * k + 3 && !mdl_full) begin
               mdl_buf = vi.mlv[k]; mdl_full = 1'b1;
            end
            if (vi.nbits >= 8 * (k + 1)) begin
               vo.exp_rx[vo.exp_rx_n] = vi.mo[k];
               vo.exp_rx_n += 1;
               mdl_last_rx = vi.mo[k];
               cur = mdl_full ? mdl_buf : 8'hFF;
               if (!mdl_full) vo.exp_und += 1;
               mdl_full = 1'b0;
            end
         end
      end
   endtask

   // Run one transfer as the SPI master and compare the results. A
   // non-negative rst_bit pulses reset just before that bit and checks the
   // reset values instead.
   task automatic applyStimulus(input vec_t v, input int rst_bit, input string tag);
      logic [1:0][7:0] got_mi;
      logic [7:0]      mask;
      int              rx0, u0, k, i, nb, ngot;
      got_mi = '0;
      cpol = v.cpol; cpha = v.cpha; sck = v.cpol; mosi = 1'b0;
      tick(4);
      if (v.pre_en) begin
         tx_data = v.pre; tx_load = 1'b1; tick(1); tx_load = 1'b0;
         checkOutput({tag, " tx_ready_after_load"}, tx_ready, 0);
      end
      if (v.pre2_en) begin
         tx_data = v.pre2; tx_load = 1'b1; tick(1); tx_load = 1'b0;
      end
      rx0 = rx_log.size();
      u0  = und_total;
      mosi = v.mo[0][7];
      ss_n = 1'b0;
      tick(2 * HALF);
      for (int b = 0; b < v.nbits; b++) begin
         k = b / 8;
         i = 7 - (b % 8);
         if (b == rst_bit) begin
            reset = 1'b1; tick(1); reset = 1'b0;
            checkOutput({tag, " miso"}, miso, 0);
            checkOutput({tag, " tx_ready"}, tx_ready, 1);
            checkOutput({tag, " rx_data"}, rx_data, 0);
            checkOutput({tag, " rx_valid"}, rx_valid, 0);
            checkOutput({tag, " underrun"}, underrun, 0);
            checkOutput({tag, " selected"}, selected, 0);
            ss_n = 1'b1; sck = v.cpol;
            tick(8);
            return;
         end
         if (b == 1) checkOutput({tag, " selected_mid"}, selected, 1);
         if (b % 8 == 3 && v.ml[k]) begin
            tx_data = v.mlv[k]; tx_load = 1'b1;
         end
         if (!v.cpha) begin
            got_mi[k][i] = miso;
            sck = ~v.cpol;
            halfWait();
            sck = v.cpol;
            if (b + 1 < v.nbits) mosi = v.mo[(b + 1) / 8][7 - ((b + 1) % 8)];
            halfWait();
         end else begin
            sck = ~v.cpol;
            mosi = v.mo[k][i];
            halfWait();
            got_mi[k][i] = miso;
            sck = v.cpol;
            halfWait();
         end
      end
      tick(HALF);
      ss_n = 1'b1;
      tick(8);
      for (int j = 0; j < v.nbytes; j++) begin
         nb = v.nbits - 8 * j;
         if (nb > 8) nb = 8;
         if (nb > 0) begin
            mask = 8'hFF << (8 - nb);
            checkOutput($sformatf("%s miso_byte%0d", tag, j), got_mi[j] & mask,
                        v.exp_mi[j] & mask);
         end
      end
      ngot = rx_log.size() - rx0;
      checkOutput({tag, " rx_count"}, ngot, v.exp_rx_n);
      for (int j = 0; j < ngot && j < v.exp_rx_n; j++)
         checkOutput($sformatf("%s rx_byte%0d", tag, j), rx_log[rx0 + j], v.exp_rx[j]);
      checkOutput({tag, " underruns"}, und_total - u0, v.exp_und);
      checkOutput({tag, " rx_data_held"}, rx_data, mdl_last_rx);
      checkOutput({tag, " tx_ready_end"}, tx_ready, !mdl_full);
      checkOutput({tag, " miso_idle"}, miso, 0);
      checkOutput({tag, " selected_idle"}, selected, 0);
   endtask

   initial begin
      vec_t v;
      vec_t e;
      reset = 1'b1; sck = 1'b0; ss_n = 1'b1; mosi = 1'b0;
      cpol = 1'b0; cpha = 1'b0; tx_data = 8'h00; tx_load = 1'b0;
      mdl_full = 1'b0; mdl_buf = 8'h00; mdl_last_rx = 8'h00;
      tick(4);
      reset = 1'b0;
      tick(1);
      checkOutput("reset miso", miso, 0);
      checkOutput("reset tx_ready", tx_ready, 1);
      checkOutput("reset rx_data", rx_data, 0);
      checkOutput("reset rx_valid", rx_valid, 0);
      checkOutput("reset underrun", underrun, 0);
      checkOutput("reset selected", selected, 0);

      //             cpl cph pe pre  nby nbi mo0    mo1    l0 lv0    exmi0  exmi1  rxn rx0    rx1    und
      tbl[0] = mk(0, 0, 1, 8'hA5, 1, 8,  8'h3C, 8'h00, 0, 8'h00, 8'hA5, 8'h00, 1, 8'h3C, 8'h00, 1);
      tbl[1] = mk(0, 1, 1, 8'hA5, 1, 8,  8'h3C, 8'h00, 0, 8'h00, 8'hA5, 8'h00, 1, 8'h3C, 8'h00, 1);
      tbl[2] = mk(1, 0, 1, 8'hA5, 1, 8,  8'h3C, 8'h00, 0, 8'h00, 8'hA5, 8'h00, 1, 8'h3C, 8'h00, 1);
      tbl[3] = mk(1, 1, 1, 8'hA5, 1, 8,  8'h3C, 8'h00, 0, 8'h00, 8'hA5, 8'h00, 1, 8'h3C, 8'h00, 1);
      tbl[4] = mk(0, 0, 0, 8'h00, 1, 8,  8'h81, 8'h00, 0, 8'h00, 8'hFF, 8'h00, 1, 8'h81, 8'h00, 2);
      tbl[5] = mk(0, 0, 0, 8'h00, 2, 16, 8'h11, 8'h22, 1, 8'h5A, 8'hFF, 8'h5A, 2, 8'h11, 8'h22, 2);
      tbl[6] = mk(0, 0, 1, 8'hC3, 1, 5,  8'h66, 8'h00, 0, 8'h00, 8'hC3, 8'h00, 0, 8'h00, 8'h00, 0);
      tbl[7] = mk(0, 0, 1, 8'h96, 1, 8,  8'h99, 8'h00, 0, 8'h00, 8'h96, 8'h00, 1, 8'h99, 8'h00, 1);
      tbl[8] = mk(1, 1, 1, 8'h0F, 2, 16, 8'hE7, 8'h18, 1, 8'h3C, 8'h0F, 8'h3C, 2, 8'hE7, 8'h18, 1);
      tbl[8].pre2_en = 1'b1;
      tbl[8].pre2    = 8'hF0;
      tbl[9] = mk(1, 0, 1, 8'h44, 2, 11, 8'h12, 8'h34, 1, 8'h77, 8'h44, 8'h77, 1, 8'h12, 8'h00, 0);

      for (int t = 0; t < 10; t++) begin
         modelPredict(tbl[t], e);
         applyStimulus(tbl[t], -1, $sformatf("vec%0d", t));
      end

      v = mk(0, 0, 1, 8'h5A, 1, 8, 8'hF0, 8'h00, 0, 8'h00, 8'h5A, 8'h00, 1, 8'hF0, 8'h00, 0);
      applyStimulus(v, 4, "reset_mid");
      mdl_full = 1'b0;
      mdl_last_rx = 8'h00;

      for (int r = 0; r < 40; r++) begin
         v = mk(0, 0, 0, 8'h00, 1, 8, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0);
         v.cpol    = 1'($urandom_range(0, 1));
         v.cpha    = 1'($urandom_range(0, 1));
         v.pre_en  = 1'($urandom_range(0, 1));
         v.pre     = 8'($urandom);
         v.pre2_en = ($urandom_range(0, 3) == 0);
         v.pre2    = 8'($urandom);
         v.nbytes  = $urandom_range(1, 2);
         v.nbits   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8 * v.nbytes - 1)
                                                 : 8 * v.nbytes;
         v.mo[0]   = 8'($urandom);
         v.mo[1]   = 8'($urandom);
         v.ml      = 2'($urandom_range(0, 3));
         v.mlv[0]  = 8'($urandom);
         v.mlv[1]  = 8'($urandom);
         modelPredict(v, e);
         applyStimulus(e, -1, $sformatf("rnd%0d", r));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
